// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_pkg
// Description : Shared types and defaults for the sequence-detector family.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_t;

  localparam int   SEQ_W          = 8;
  localparam logic SEQ_IDLE_LEVEL = 1'b0;

endpackage : seq_pkg
`default_nettype wire

// File: rtl/seq_serializer.sv
`default_nettype none
// ============================================================================
// Module      : seq_serializer
// Description : MSB-first parallel-to-serial front end for the sequence
//               detectors. Optional even-parity bit: SEQ_SERIALIZER_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_serializer
  import seq_pkg::*;
#(
  parameter int   W          = SEQ_W,
  parameter logic IDLE_LEVEL = SEQ_IDLE_LEVEL
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         dout,
  output logic         dout_valid,
  output logic         dout_last
);

  localparam int             CW         = $clog2(W);
  localparam logic [CW-1:0]  c_cnt_last = CW'(W - 1);
  localparam logic [CW-1:0]  c_cnt_pen  = CW'(W - 2);

  state_t          r_state;
  logic [W-1:0]    r_shift;     // remaining bits, next one to emit at MSB
  logic [CW-1:0]   r_cnt;
  logic            r_dout;
  logic            r_dout_valid;
  logic            r_dout_last;
`ifdef SEQ_SERIALIZER_PARITY_EN
  logic            r_par;
`endif

  logic w_last_bit;
  logic w_accept;

`ifdef SEQ_SERIALIZER_PARITY_EN
  assign w_last_bit = (r_state == ST_PAR);
`else
  assign w_last_bit = (r_state == ST_SHIFT) && (r_cnt == c_cnt_last);
`endif

  assign in_ready   = (r_state == ST_IDLE) || w_last_bit;
  assign w_accept   = in_valid && in_ready;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign dout_last  = r_dout_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_dout       <= IDLE_LEVEL;
      r_dout_valid <= 1'b0;
      r_dout_last  <= 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
      r_par        <= 1'b0;
`endif
    end else if (w_accept) begin
      // Accept has priority so a new word follows the last bit with no gap.
      r_state      <= ST_SHIFT;
      r_shift      <= {in_data[W-2:0], 1'b0};
      r_cnt        <= '0;
      r_dout       <= in_data[W-1];
      r_dout_valid <= 1'b1;
      r_dout_last  <= 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
      r_par        <= ^in_data;
`endif
    end else begin
      case (r_state)
        ST_SHIFT: begin
          if (r_cnt == c_cnt_last) begin
`ifdef SEQ_SERIALIZER_PARITY_EN
            r_state      <= ST_PAR;
            r_dout       <= r_par;
            r_dout_valid <= 1'b1;
            r_dout_last  <= 1'b1;
`else
            r_state      <= ST_IDLE;
            r_dout       <= IDLE_LEVEL;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
`endif
          end else begin
            r_shift      <= r_shift << 1;
            r_cnt        <= r_cnt + CW'(1);
            r_dout       <= r_shift[W-1];
            r_dout_valid <= 1'b1;
`ifdef SEQ_SERIALIZER_PARITY_EN
            r_dout_last  <= 1'b0;
`else
            r_dout_last  <= (r_cnt == c_cnt_pen);
`endif
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_dout       <= IDLE_LEVEL;
          r_dout_valid <= 1'b0;
          r_dout_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule : seq_serializer
`default_nettype wire
